// File: rtl/ledcomm_sniff.sv
// Passive Ledcomm receiver: classifies sensor pulses, rebuilds 16-bit words into a 16-deep FIFO.
// Optional LEDCOMM_SNIFF_STATS_EN implements the invalid-pulse counter; otherwise err_count reads 0.
module ledcomm_sniff #(
  parameter int GAP_MAX     = 40,
  parameter int LINK_PULSES = 18
) (
  input  logic        clk,
  input  logic        resetq,
  input  logic        sunshine,
  input  logic        rd,
  input  logic        clr_ovf,
  output logic [15:0] rx_data,
  output logic        valid,
  output logic        link,
  output logic        overflow,
  output logic [15:0] err_count
);

  typedef enum logic [1:0] {CLS_ONE, CLS_ZERO, CLS_EOW, CLS_INV} pulse_cls_e;

  localparam logic [5:0] GAP_W  = 6'(GAP_MAX);
  localparam logic [4:0] LINK_W = 5'(LINK_PULSES);

  logic        s_q;
  logic [4:0]  hi_cnt_q, hi_cnt_d;
  logic [5:0]  lo_cnt_q, lo_cnt_d;
  logic        ev_q;
  pulse_cls_e  cls_q, cls_d;
  logic [15:0] shreg_q, shreg_d;
  logic [4:0]  pcnt_q, pcnt_d, pcnt_inc;
  logic [15:0] mem_q [16];
  logic [3:0]  wp_q, wp_d, rp_q, rp_d;
  logic        ovf_q, ovf_d;
  logic        pulse_end, gap_hit, push, full, do_push, do_pop;

  // A pulse ends on the first dark sample; hi_cnt_q still holds the run length then.
  assign pulse_end = !s_q && (hi_cnt_q != 5'd0);
  assign gap_hit   = (lo_cnt_q == GAP_W);
  assign link      = (pcnt_q == LINK_W);
  assign pcnt_inc  = link ? pcnt_q : pcnt_q + 5'd1;

  always_comb begin
    hi_cnt_d = '0;
    lo_cnt_d = '0;
    if (s_q) hi_cnt_d = (hi_cnt_q == 5'd31) ? hi_cnt_q : hi_cnt_q + 5'd1;
    else     lo_cnt_d = (lo_cnt_q == 6'd63) ? lo_cnt_q : lo_cnt_q + 6'd1;
    if (hi_cnt_q >= 5'd3 && hi_cnt_q <= 5'd6)       cls_d = CLS_ONE;
    else if (hi_cnt_q >= 5'd7 && hi_cnt_q <= 5'd10) cls_d = CLS_ZERO;
    else if (hi_cnt_q >= 5'd11 && hi_cnt_q <= 5'd14) cls_d = CLS_EOW;
    else                                              cls_d = CLS_INV;
  end

  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      s_q      <= 1'b0;
      hi_cnt_q <= '0;
      lo_cnt_q <= '0;
      ev_q     <= 1'b0;
      cls_q    <= CLS_INV;
    end else begin
      s_q      <= sunshine;
      hi_cnt_q <= hi_cnt_d;
      lo_cnt_q <= lo_cnt_d;
      ev_q     <= pulse_end;
      cls_q    <= cls_d;
    end
  end

  always_comb begin
    shreg_d = shreg_q;
    pcnt_d  = pcnt_q;
    push    = 1'b0;
    if (ev_q) begin
      unique case (cls_q)
        CLS_ONE:  begin shreg_d = {shreg_q[14:0], 1'b1}; pcnt_d = pcnt_inc; end
        CLS_ZERO: begin shreg_d = {shreg_q[14:0], 1'b0}; pcnt_d = pcnt_inc; end
        CLS_EOW:  begin push = link; shreg_d = '0; pcnt_d = pcnt_inc; end
        default:  begin shreg_d = '0; pcnt_d = '0; end
      endcase
    end
    if (gap_hit) begin
      shreg_d = '0;
      pcnt_d  = '0;
    end
  end

  // One slot stays empty so wp==rp unambiguously means empty.
  assign valid   = (wp_q != rp_q);
  assign full    = ((wp_q - rp_q) == 4'd15);
  assign do_push = push && !full;
  assign do_pop  = rd && valid;
  assign wp_d    = do_push ? wp_q + 4'd1 : wp_q;
  assign rp_d    = do_pop ? rp_q + 4'd1 : rp_q;
  assign ovf_d   = (push && full) ? 1'b1 : (clr_ovf ? 1'b0 : ovf_q);

  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      shreg_q <= '0;
      pcnt_q  <= '0;
      wp_q    <= '0;
      rp_q    <= '0;
      ovf_q   <= 1'b0;
    end else begin
      shreg_q <= shreg_d;
      pcnt_q  <= pcnt_d;
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      ovf_q   <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wp_q] <= shreg_q;
  end

  assign rx_data  = valid ? mem_q[rp_q] : 16'h0000;
  assign overflow = ovf_q;

`ifdef LEDCOMM_SNIFF_STATS_EN
  logic [15:0] err_q;
  logic        inv;
  assign inv = ev_q && (cls_q == CLS_INV);
  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq)  err_q <= '0;
    else if (inv) err_q <= err_q + 16'd1;
  end
  assign err_count = err_q;
`else
  assign err_count = 16'h0000;
`endif

endmodule
